// File: rtl/uart_tx_param_pkg.sv
// Shared constants and FSM state type for the parametrised UART transmitter.
package uart_tx_param_pkg;
    localparam int CLK_HZ    = 100_000_000;
    localparam int BAUD_SLOW = 9600;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;
endpackage

// File: rtl/uart_tx_param_if.sv
// Upstream write handshake plus serial line and status for the UART transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) ();
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in;
    logic                 out;
    logic                 busy;
    logic                 done;
    logic [LW-1:0]        level;

    modport master (output in_valid, in, input in_ready, out, busy, done, level);
    modport slave  (input in_valid, in, output in_ready, out, busy, done, level);
endinterface

// File: rtl/uart_tx_param_fifo.sv
// Synchronous input FIFO; pointers carry one extra wrap bit so full/empty/level fall out of the difference.
module uart_tx_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       TXclk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    assign level_o = wr_q - rd_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge TXclk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge TXclk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: FIFO-fed frame FSM with baud divider, configurable data width, parity and stop bits.
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD_SLOW,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            TXclk,
    input  logic            rst,
    input  logic            en,
    uart_tx_param_if.slave  bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 full, empty, push, pop, tick, done_c, out_c;
    logic [LW-1:0]        level;

    assign push = bus.in_valid && !full;
    assign tick = en && (baud_q == BW'(CLKS_PER_BIT - 1));

    uart_tx_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .TXclk   (TXclk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (bus.in),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pop     = 1'b0;
        done_c  = 1'b0;
        if (state_q != ST_IDLE && en) baud_d = tick ? '0 : baud_q + BW'(1);
        case (state_q)
            ST_IDLE:   if (en && !empty) pop = 1'b1;
            ST_START:  if (tick) begin
                state_d = ST_DATA;
                bit_d   = '0;
            end
            ST_DATA:   if (tick) begin
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'(DATA_BITS - 1)) begin
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick) begin
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'(STOP_BITS - 1)) begin
                    done_c  = 1'b1;
                    bit_d   = '0;
                    state_d = ST_IDLE;
                    pop     = !empty;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
        // A pop always launches a fresh frame, including back-to-back from STOP
        if (pop) begin
            state_d = ST_START;
            sh_d    = fifo_dout;
            par_d   = (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge TXclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_START:  out_c = 1'b0;
            ST_DATA:   out_c = sh_q[0];
            ST_PARITY: out_c = par_q;
            default:   out_c = 1'b1;
        endcase
    end

    assign bus.out      = out_c;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_c;
    assign bus.in_ready = !full;
    assign bus.level    = level;
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench: 8N1/8E1/8O1/9O2 transmitters; frame-level reference model on the 8N1 unit plus table and corner sequences.
module tb_uart_tx_param;
    import uart_tx_param_pkg::*;

    localparam int CPB = 4;
    localparam int ML  = 10 * CPB;

    logic       TXclk = 1'b0;
    logic       rst   = 1'b1;
    logic       en_a  = 1'b1;
    logic       en_on = 1'b1;
    logic [3:0] vld   = '0;
    logic [8:0] din   = '0;
    int         checks = 0, failures = 0, cyc = 0;
    int         done_at[$];

    always #5 TXclk = ~TXclk;
    always @(posedge TXclk) cyc <= cyc + 1;

    uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
    uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();
    uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc ();
    uart_tx_param_if #(.DATA_BITS(9), .FIFO_DEPTH(4)) ifd ();

    assign ifa.in_valid = vld[0]; assign ifa.in = din[7:0];
    assign ifb.in_valid = vld[1]; assign ifb.in = din[7:0];
    assign ifc.in_valid = vld[2]; assign ifc.in = din[7:0];
    assign ifd.in_valid = vld[3]; assign ifd.in = din;

    uart_tx_param #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        dut_a (.TXclk(TXclk), .rst(rst), .en(en_a), .bus(ifa));
    uart_tx_param #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        dut_b (.TXclk(TXclk), .rst(rst), .en(en_on), .bus(ifb));
    uart_tx_param #(.DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        dut_c (.TXclk(TXclk), .rst(rst), .en(en_on), .bus(ifc));
    uart_tx_param #(.DATA_BITS(9), .PARITY(PAR_ODD), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4))
        dut_d (.TXclk(TXclk), .rst(rst), .en(en_on), .bus(ifd));

    logic [3:0] out_w, busy_w, done_w;
    assign out_w  = {ifd.out,  ifc.out,  ifb.out,  ifa.out};
    assign busy_w = {ifd.busy, ifc.busy, ifb.busy, ifa.busy};
    assign done_w = {ifd.done, ifc.done, ifb.done, ifa.done};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge TXclk);
        #1;
    endtask

    // Frame-level reference for the 8N1 unit: a word queue and an elapsed-enabled-cycle count per frame.
    logic [7:0]  m_q[$];
    bit          m_act = 1'b0;
    int          m_e   = 0;
    logic [15:0] m_vec = '1;

    always @(negedge TXclk) begin : sb
        logic e_out, e_done, rdy;
        logic [7:0] w;
        if (rst) begin
            m_q.delete();
            m_act = 1'b0;
            m_e   = 0;
        end
        e_out  = m_act ? m_vec[m_e / CPB] : 1'b1;
        e_done = m_act && en_a && (m_e == ML - 1);
        rdy    = (m_q.size() < 4);
        chk("a_out",   ifa.out,      e_out);
        chk("a_busy",  ifa.busy,     m_act);
        chk("a_done",  ifa.done,     e_done);
        chk("a_ready", ifa.in_ready, rdy);
        chk("a_level", ifa.level,    m_q.size());
        if (ifa.done) done_at.push_back(cyc);
        if (!rst) begin
            if (m_act && en_a) begin
                m_e++;
                if (m_e == ML) m_act = 1'b0;
            end
            if (!m_act && en_a && m_q.size() != 0) begin
                w     = m_q.pop_front();
                m_vec = {7'h7F, w, 1'b0};
                m_act = 1'b1;
                m_e   = 0;
            end
            if (vld[0] && rdy) m_q.push_back(din[7:0]);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge TXclk);
        while ((ifa.busy || ifa.level != 0) && n < 2000) begin
            @(negedge TXclk);
            n++;
        end
        chk("idle_wait", ifa.busy, 1'b0);
        tick();
    endtask

    task automatic send_check(input int sel, input logic [8:0] data, input logic [15:0] vec,
                              input int nbits, input string nm);
        din = data;
        vld[sel] = 1'b1;
        tick();
        vld = '0;
        tick();
        for (int c = 0; c < nbits * CPB; c++) begin
            @(negedge TXclk);
            chk({nm, "_out"},  out_w[sel],  vec[c / CPB]);
            chk({nm, "_busy"}, busy_w[sel], 1'b1);
            chk({nm, "_done"}, done_w[sel], (c == nbits * CPB - 1));
        end
        @(negedge TXclk);
        chk({nm, "_end_busy"}, busy_w[sel], 1'b0);
        chk({nm, "_end_done"}, done_w[sel], 1'b0);
        tick();
    endtask

    typedef struct {
        int          sel;
        logic [8:0]  data;
        logic [15:0] vec;
        int          nbits;
        string       nm;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int acc, bc, ones, dc, nd;
        bit saw_full;
        logic r;
        tbl[0] = '{0, 9'h055, 16'h02AA, 10, "n1_55"};
        tbl[1] = '{0, 9'h000, 16'h0200, 10, "n1_00"};
        tbl[2] = '{0, 9'h0FF, 16'h03FE, 10, "n1_ff"};
        tbl[3] = '{1, 9'h096, 16'h052C, 11, "e1_96"};
        tbl[4] = '{2, 9'h096, 16'h072C, 11, "o1_96"};
        tbl[5] = '{1, 9'h001, 16'h0602, 11, "e1_01"};
        tbl[6] = '{2, 9'h001, 16'h0402, 11, "o1_01"};
        tbl[7] = '{3, 9'h1FF, 16'h1BFE, 13, "o2_1ff"};
        tbl[8] = '{3, 9'h100, 16'h1A00, 13, "o2_100"};

        repeat (3) @(posedge TXclk);
        @(negedge TXclk);
        chk("rst_out_all",  out_w,  4'hF);
        chk("rst_busy_all", busy_w, 4'h0);
        tick();
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].sel == 0) wait_idle();
            send_check(tbl[i].sel, tbl[i].data, tbl[i].vec, tbl[i].nbits, tbl[i].nm);
        end

        // six pushes back to back: FIFO fills, frames run contiguously
        wait_idle();
        done_at.delete();
        acc = 0; saw_full = 1'b0;
        din = 9'($urandom_range(0, 255));
        vld[0] = 1'b1;
        for (int n = 0; n < 400 && acc < 6; n++) begin
            @(negedge TXclk);
            r = ifa.in_ready;
            if (!r) saw_full = 1'b1;
            tick();
            if (r) begin
                acc++;
                din = 9'($urandom_range(0, 255));
            end
        end
        vld = '0;
        chk("burst_accepted", acc, 6);
        chk("burst_saw_full", saw_full, 1'b1);
        wait_idle();
        chk("burst_dones", done_at.size(), 6);
        for (int i = 1; i < done_at.size(); i++) chk("burst_gap", done_at[i] - done_at[i-1], ML);

        // en low for 10 cycles inside data bit 3
        wait_idle();
        din = 9'h008; vld[0] = 1'b1;
        tick();
        vld = '0;
        tick();
        bc = 0; ones = 0; dc = -1;
        for (int c = 0; c < 70; c++) begin
            en_a = !(c >= 17 && c <= 26);
            @(negedge TXclk);
            if (ifa.busy) bc++;
            if (c < 46 && ifa.out) ones++;
            if (ifa.done) dc = c;
            tick();
        end
        en_a = 1'b1;
        chk("stall_busy_len", bc, 50);
        chk("stall_bit3_len", ones, 14);
        chk("stall_done_cyc", dc, 49);

        // reset mid data bit 5 with two words queued
        wait_idle();
        vld[0] = 1'b1;
        din = 9'h0A5; tick();
        din = 9'h05A; tick();
        din = 9'h0F0; tick();
        vld = '0;
        chk("rst_pre_level", ifa.level, 2);
        repeat (24) tick();
        rst = 1'b1;
        #1;
        chk("rstmid_out",   ifa.out,      1'b1);
        chk("rstmid_busy",  ifa.busy,     1'b0);
        chk("rstmid_level", ifa.level,    0);
        chk("rstmid_ready", ifa.in_ready, 1'b1);
        chk("rstmid_done",  ifa.done,     1'b0);
        tick(); tick();
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge TXclk);
            if (ifa.done || ifa.busy) nd++;
        end
        chk("rstmid_quiet", nd, 0);
        tick();
        send_check(0, 9'h0C3, 16'h0386, 10, "post_rst_c3");

        // random traffic with random enable, busy then sparse
        for (int n = 0; n < 3000; n++) begin
            vld[0] = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            din    = 9'($urandom_range(0, 255));
            en_a   = ($urandom_range(0, 9) != 0);
            tick();
        end
        vld = '0; en_a = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
